compute_cluster_seq: RTL and testbench

- Parametrised sequencer that drives a compute cluster through complete multi-chunk passes: per-unit filter load, broadcast IFM load, ping-pong bank swap, chunk start/end handshake, and serial drain of one accumulator buffer per unit.
- Sits between the DMA stream and the cluster's write, control and readout ports, replacing hand-driven control.

---
 rtl/compute_cluster_seq_if.sv | 58 +++++
 rtl/compute_cluster_seq.sv | 190 +++++++++++++++++++
 tb/tb_compute_cluster_seq.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compute_cluster_seq_if.sv
// Bundle of signals between the compute-cluster sequencer and its surroundings:
// the DMA input stream, the cluster's filter/IFM write port, its chunk
// control and its accumulator readout, plus the output stream.
//   master : used by compute_cluster_seq (drives every *_o signal)
//   slave  : used by the environment (drives every *_i signal)
interface compute_cluster_seq_if #(
  parameter int COMPUTE_UNIT_NUM = 32,
  parameter int OUTPUT_BUF_NUM   = 32,
  parameter int OUTPUT_BUF_SIZE  = 32,
  parameter int MEM_SIZE         = 128,
  parameter int BUS_SIZE         = 8
);
  localparam int BEATS = MEM_SIZE / BUS_SIZE;

  logic                                start_i;
  logic [$clog2(COMPUTE_UNIT_NUM):0]   cfg_unit_num_i;
  logic [7:0]                          cfg_chunk_num_i;
  logic [$clog2(OUTPUT_BUF_NUM)-1:0]   cfg_acc_buf_i;
  logic                                done_o;
  logic                                in_valid_i;
  logic                                in_ready_o;
  logic [BUS_SIZE*9-1:0]               in_dat_i;
  logic [BUS_SIZE-1:0]                 wr_sparsemap_o;
  logic [BUS_SIZE*8-1:0]               wr_nonzero_data_o;
  logic [$clog2(BEATS)-1:0]            wr_count_o;
  logic                                filter_wr_valid_o;
  logic [$clog2(COMPUTE_UNIT_NUM)-1:0] filter_wr_order_sel_o;
  logic                                ifm_wr_valid_o;
  logic                                wr_sel_o;
  logic                                rd_sel_o;
  logic                                init_o;
  logic                                chunk_start_o;
  logic                                chunk_end_i;
  logic [$clog2(OUTPUT_BUF_NUM)-1:0]   acc_buf_sel_o;
  logic [$clog2(COMPUTE_UNIT_NUM)-1:0] com_unit_out_buf_sel_o;
  logic [OUTPUT_BUF_SIZE-1:0]          out_buf_dat_i;
  logic                                out_valid_o;
  logic                                out_ready_i;
  logic [OUTPUT_BUF_SIZE-1:0]          out_data_o;

  modport master (
    input  start_i, cfg_unit_num_i, cfg_chunk_num_i, cfg_acc_buf_i,
           in_valid_i, in_dat_i, chunk_end_i, out_buf_dat_i, out_ready_i,
    output done_o, in_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_count_o,
           filter_wr_valid_o, filter_wr_order_sel_o, ifm_wr_valid_o, wr_sel_o,
           rd_sel_o, init_o, chunk_start_o, acc_buf_sel_o,
           com_unit_out_buf_sel_o, out_valid_o, out_data_o
  );

  modport slave (
    output start_i, cfg_unit_num_i, cfg_chunk_num_i, cfg_acc_buf_i,
           in_valid_i, in_dat_i, chunk_end_i, out_buf_dat_i, out_ready_i,
    input  done_o, in_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_count_o,
           filter_wr_valid_o, filter_wr_order_sel_o, ifm_wr_valid_o, wr_sel_o,
           rd_sel_o, init_o, chunk_start_o, acc_buf_sel_o,
           com_unit_out_buf_sel_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/compute_cluster_seq.sv
// Sequencer driving a compute cluster through complete multi-chunk passes:
// per-unit filter load, broadcast IFM load, ping-pong bank swap, chunk
// start/end handshake, then serial drain of one accumulator word per unit.
// Ports:
//   clk_i - clock
//   rst_i - asynchronous active-high reset (drops any partial pass)
//   bus   - compute_cluster_seq_if.master: config/start/done, input stream,
//           cluster write/control/readout ports and output stream
module compute_cluster_seq #(
  parameter int COMPUTE_UNIT_NUM = 32,
  parameter int OUTPUT_BUF_NUM   = 32,
  parameter int OUTPUT_BUF_SIZE  = 32,
  parameter int MEM_SIZE         = 128,
  parameter int BUS_SIZE         = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  compute_cluster_seq_if.master bus
);
  localparam int BEATS = MEM_SIZE / BUS_SIZE;
  localparam int UW    = $clog2(COMPUTE_UNIT_NUM) + 1;
  localparam int IW    = $clog2(COMPUTE_UNIT_NUM);
  localparam int BW    = $clog2(BEATS);
  localparam int AW    = $clog2(OUTPUT_BUF_NUM);
  localparam int DW    = BUS_SIZE * 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FLT, S_IFM, S_SETTLE, S_START, S_WAIT, S_DRAIN, S_DOUT
  } state_t;

  state_t state, state_nx;

  logic [UW-1:0]              unit_num;
  logic [UW-1:0]              unit_clamp;
  logic [7:0]                 chunk_num;
  logic [7:0]                 chunk_cnt;
  logic [IW-1:0]              unit_cnt;   // filter target unit, then drain unit
  logic [BW-1:0]              beat_cnt;
  logic                       blank;
  logic [AW-1:0]              acc_sel;
  logic                       wr_sel, rd_sel;
  logic [BUS_SIZE-1:0]        wr_smap;
  logic [DW-1:0]              wr_data;
  logic [BW-1:0]              wr_count;
  logic [IW-1:0]              order_sel;
  logic                       flt_wv, ifm_wv;
  logic [OUTPUT_BUF_SIZE-1:0] out_data;
  logic                       out_valid;
  logic                       done;
  logic                       in_ready, chunk_start, init;
  logic                       hs, out_hs, last_beat, last_unit, last_chunk;

  assign hs         = bus.in_valid_i && in_ready;
  assign out_hs     = out_valid && bus.out_ready_i;
  assign last_beat  = (beat_cnt == BW'(BEATS - 1));
  assign last_unit  = ({1'b0, unit_cnt} == (unit_num - UW'(1)));
  assign last_chunk = ((chunk_cnt + 8'd1) == chunk_num);

  always_comb begin
    unit_clamp = bus.cfg_unit_num_i;
    if (unit_clamp == '0)
      unit_clamp = UW'(1);
    else if (unit_clamp > UW'(COMPUTE_UNIT_NUM))
      unit_clamp = UW'(COMPUTE_UNIT_NUM);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    chunk_start = 1'b0;
    init        = 1'b0;
    case (state)
      S_IDLE:   if (bus.start_i) state_nx = S_FLT;
      S_FLT: begin
        in_ready = 1'b1;
        if (bus.in_valid_i && last_beat && last_unit) state_nx = S_IFM;
      end
      S_IFM: begin
        in_ready = 1'b1;
        if (bus.in_valid_i && last_beat) state_nx = S_SETTLE;
      end
      // SETTLE is the cycle the last IFM beat is on the write bus
      S_SETTLE: state_nx = S_START;
      S_START: begin
        chunk_start = 1'b1;
        init        = (chunk_cnt == '0);
        state_nx    = S_WAIT;
      end
      S_WAIT:   if (!blank && bus.chunk_end_i) state_nx = last_chunk ? S_DRAIN : S_FLT;
      S_DRAIN:  state_nx = S_DOUT;
      S_DOUT: begin
        if (out_hs) state_nx = last_unit ? S_IDLE : S_DRAIN;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      unit_num  <= '0;
      chunk_num <= '0;
      chunk_cnt <= '0;
      unit_cnt  <= '0;
      beat_cnt  <= '0;
      blank     <= 1'b0;
      acc_sel   <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_smap   <= '0;
      wr_data   <= '0;
      wr_count  <= '0;
      order_sel <= '0;
      flt_wv    <= 1'b0;
      ifm_wv    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      flt_wv <= 1'b0;
      ifm_wv <= 1'b0;
      done   <= 1'b0;
      if (hs) begin
        wr_smap   <= bus.in_dat_i[DW +: BUS_SIZE];
        wr_data   <= bus.in_dat_i[DW-1:0];
        wr_count  <= beat_cnt;
        order_sel <= unit_cnt;
        flt_wv    <= (state == S_FLT);
        ifm_wv    <= (state == S_IFM);
        beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
        if (last_beat && state == S_FLT)
          unit_cnt <= last_unit ? '0 : unit_cnt + 1'b1;
      end
      case (state)
        S_IDLE: if (bus.start_i) begin
          unit_num  <= unit_clamp;
          chunk_num <= (bus.cfg_chunk_num_i == 8'd0) ? 8'd1 : bus.cfg_chunk_num_i;
          acc_sel   <= bus.cfg_acc_buf_i;
          chunk_cnt <= '0;
          unit_cnt  <= '0;
          beat_cnt  <= '0;
        end
        S_START: begin
          rd_sel <= wr_sel;
          wr_sel <= ~wr_sel;
          blank  <= 1'b1;
        end
        S_WAIT: begin
          if (blank)                 blank     <= 1'b0;
          else if (bus.chunk_end_i)  chunk_cnt <= chunk_cnt + 8'd1;
        end
        S_DRAIN: begin
          out_data  <= bus.out_buf_dat_i;
          out_valid <= 1'b1;
        end
        S_DOUT: if (out_hs) begin
          out_valid <= 1'b0;
          if (last_unit) begin
            done     <= 1'b1;
            unit_cnt <= '0;
          end else begin
            unit_cnt <= unit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done_o                 = done;
  assign bus.in_ready_o             = in_ready;
  assign bus.wr_sparsemap_o         = wr_smap;
  assign bus.wr_nonzero_data_o      = wr_data;
  assign bus.wr_count_o             = wr_count;
  assign bus.filter_wr_valid_o      = flt_wv;
  assign bus.filter_wr_order_sel_o  = order_sel;
  assign bus.ifm_wr_valid_o         = ifm_wv;
  assign bus.wr_sel_o               = wr_sel;
  assign bus.rd_sel_o               = rd_sel;
  assign bus.init_o                 = init;
  assign bus.chunk_start_o          = chunk_start;
  assign bus.acc_buf_sel_o          = acc_sel;
  assign bus.com_unit_out_buf_sel_o = unit_cnt;
  assign bus.out_valid_o            = out_valid;
  assign bus.out_data_o             = out_data;
endmodule

// File: tb/tb_compute_cluster_seq.sv
// Scoreboard bench for compute_cluster_seq with a 4-unit cluster, 16 beats
// per memory. Each pass pushes its expected writes, chunk starts and output
// words into queues; a negedge monitor pops and compares as the DUT emits.
module tb_compute_cluster_seq;
  localparam int N     = 4;
  localparam int BUS   = 8;
  localparam int MEM   = 128;
  localparam int OBN   = 32;
  localparam int OBS   = 32;
  localparam int BEATS = MEM / BUS;
  localparam int IW    = $clog2(N);
  localparam int BW    = $clog2(BEATS);
  localparam int AW    = $clog2(OBN);

  typedef struct packed {
    logic           ifm;
    logic [IW-1:0]  unit;
    logic [BW-1:0]  cnt;
    logic [BUS*9-1:0] dat;
  } wr_t;

  typedef struct packed {
    logic init;
    logic rd;
    logic wr;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  compute_cluster_seq_if #(
    .COMPUTE_UNIT_NUM(N), .OUTPUT_BUF_NUM(OBN), .OUTPUT_BUF_SIZE(OBS),
    .MEM_SIZE(MEM), .BUS_SIZE(BUS)
  ) bus ();

  compute_cluster_seq #(
    .COMPUTE_UNIT_NUM(N), .OUTPUT_BUF_NUM(OBN), .OUTPUT_BUF_SIZE(OBS),
    .MEM_SIZE(MEM), .BUS_SIZE(BUS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  done_cnt = 0;
  int  cs_cyc   = 0;
  int  lat      = -1;
  bit  lat_arm  = 0;
  bit  out_stall = 0;
  bit  ce_hold  = 0;
  bit  pend_swap = 0;
  logic wr_m = 1'b0, rd_m = 1'b0;

  wr_t         wr_q[$];
  st_t         start_q[$];
  logic [31:0] out_q[$];

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [BUS*9-1:0] beat_val(input int g);
    return {8'(g * 37 + 5), 32'(g), ~32'(g)};
  endfunction

  function automatic logic [31:0] word(input logic [IW-1:0] k, input logic [AW-1:0] a);
    return 32'hC0DE_0000 | (32'(a) << 8) | 32'(k);
  endfunction

  // cluster accumulator readout model
  assign bus.out_buf_dat_i = word(bus.com_unit_out_buf_sel_o, bus.acc_buf_sel_o);

  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready_i = !out_stall || (cyc % 4 == 3);
    end
  end

  initial begin
    bus.chunk_end_i = 1'b0;
    forever begin
      @(negedge clk);
      if (ce_hold) bus.chunk_end_i = 1'b1;
      else if (bus.chunk_start_o && !rst) begin
        repeat (5) @(posedge clk);
        #1 bus.chunk_end_i = 1'b1;
        @(posedge clk);
        #1 bus.chunk_end_i = 1'b0;
      end else bus.chunk_end_i = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    wr_t e;
    st_t s;
    cyc++;
    if (!rst) begin
      if (bus.filter_wr_valid_o || bus.ifm_wr_valid_o) begin
        if (wr_q.size() == 0) check("wr_extra", wr_q.size(), 1);
        else begin
          e = wr_q.pop_front();
          check("wr_kind", {bus.filter_wr_valid_o, bus.ifm_wr_valid_o}, e.ifm ? 2'b01 : 2'b10);
          check("wr_count", bus.wr_count_o, e.cnt);
          if (!e.ifm) check("wr_unit", bus.filter_wr_order_sel_o, e.unit);
          check("wr_data", {bus.wr_sparsemap_o, bus.wr_nonzero_data_o}, e.dat);
        end
      end
      if (bus.chunk_start_o) begin
        cs_cyc = cyc;
        if (start_q.size() == 0) check("start_extra", start_q.size(), 1);
        else begin
          check("init", bus.init_o, start_q[0].init);
          pend_swap = 1;
        end
      end else if (pend_swap) begin
        s = start_q.pop_front();
        check("rd_sel_after_start", bus.rd_sel_o, s.rd);
        check("wr_sel_after_start", bus.wr_sel_o, s.wr);
        pend_swap = 0;
      end
      if (bus.out_valid_o) begin
        if (lat_arm) begin
          lat = cyc - cs_cyc;
          lat_arm = 0;
        end
        if (out_q.size() == 0) check("out_extra", out_q.size(), 1);
        else begin
          check("out_data", bus.out_data_o, out_q[0]);
          if (bus.out_ready_i) void'(out_q.pop_front());
        end
      end
      if (bus.done_o) done_cnt++;
    end
  end

  task automatic send_beats(input int n, input bit toggle);
    int i = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (i < n && guard < 4000) begin
      @(posedge clk); #1;
      ph = toggle ? ~ph : 1'b1;
      bus.in_valid_i = ph;
      bus.in_dat_i   = beat_val(i);
      @(negedge clk);
      if (bus.in_valid_i && bus.in_ready_o) i++;
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    if (guard >= 4000) check("beat_timeout", i, n);
  endtask

  task automatic run_pass(input int cu, input int cc, input int acc, input int eu, input int ec,
                          input bit toggle, input bit stall, input bit hold, input bit start_in_wait);
    int  d0;
    int  guard;
    wr_t e;
    for (int c = 0; c < ec; c++) begin
      for (int u = 0; u <= eu; u++) begin
        for (int b = 0; b < BEATS; b++) begin
          e.ifm  = (u == eu);
          e.unit = (u == eu) ? '0 : IW'(u);
          e.cnt  = BW'(b);
          e.dat  = beat_val((c * (eu + 1) + u) * BEATS + b);
          wr_q.push_back(e);
        end
      end
      start_q.push_back('{init: (c == 0), rd: wr_m, wr: ~wr_m});
      rd_m = wr_m;
      wr_m = ~wr_m;
    end
    for (int k = 0; k < eu; k++) out_q.push_back(word(IW'(k), AW'(acc)));
    d0        = done_cnt;
    out_stall = stall;
    ce_hold   = hold;
    lat_arm   = hold;
    @(posedge clk); #1;
    bus.cfg_unit_num_i  = 3'(cu);
    bus.cfg_chunk_num_i = 8'(cc);
    bus.cfg_acc_buf_i   = AW'(acc);
    bus.start_i         = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    send_beats(ec * (eu + 1) * BEATS, toggle);
    if (start_in_wait) begin
      repeat (3) @(posedge clk);
      #1 bus.start_i = 1'b1;
      bus.cfg_unit_num_i = 3'd3;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
    end
    guard = 0;
    while (done_cnt == d0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", guard < 4000, 1);
    repeat (5) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("acc_buf_sel", bus.acc_buf_sel_o, acc);
    check("idle_ready", bus.in_ready_o, 0);
    if (hold) check("chunk_end_blank_latency", lat, 4);
    out_stall = 0;
    ce_hold   = 0;
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.in_ready_o, bus.done_o, bus.filter_wr_valid_o, bus.ifm_wr_valid_o,
            bus.wr_sel_o, bus.rd_sel_o, bus.init_o, bus.chunk_start_o, bus.out_valid_o,
            bus.wr_count_o, bus.filter_wr_order_sel_o, bus.acc_buf_sel_o,
            bus.com_unit_out_buf_sel_o, bus.out_data_o, bus.wr_sparsemap_o,
            bus.wr_nonzero_data_o};
  endfunction

  initial begin
    int d0;
    wr_t e;
    bus.start_i         = 1'b0;
    bus.cfg_unit_num_i  = '0;
    bus.cfg_chunk_num_i = '0;
    bus.cfg_acc_buf_i   = '0;
    bus.in_valid_i      = 1'b0;
    bus.in_dat_i        = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", all_outs(), 0);
    rst = 1'b0;

    run_pass(2, 3, 2, 2, 3, 0, 0, 0, 0);   // three chunks, bank ping-pong
    run_pass(2, 1, 5, 2, 1, 1, 1, 0, 0);   // toggling valid, stalled readout
    run_pass(0, 0, 7, 1, 1, 0, 0, 0, 1);   // clamps to 1 unit / 1 chunk, start in WAIT
    run_pass(7, 1, 9, 4, 1, 1, 0, 0, 0);   // clamps to all 4 units
    run_pass(3, 2, 31, 3, 2, 0, 1, 0, 0);  // three units, two chunks, stalled readout
    run_pass(1, 1, 3, 1, 1, 0, 0, 1, 0);   // chunk_end held high entering WAIT

    // reset in the middle of the filter load
    for (int b = 0; b < 4; b++) begin
      e.ifm  = 1'b0;
      e.unit = '0;
      e.cnt  = BW'(b);
      e.dat  = beat_val(b);
      wr_q.push_back(e);
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.cfg_unit_num_i  = 3'd2;
    bus.cfg_chunk_num_i = 8'd1;
    bus.cfg_acc_buf_i   = AW'(4);
    bus.start_i         = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    send_beats(4, 0);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1;
    bus.in_dat_i   = beat_val(4);
    #3 rst = 1'b1;
    #1 check("midpass_reset_outputs", all_outs(), 0);
    bus.in_valid_i = 1'b0;
    wr_m = 1'b0;
    rd_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    check("idle_after_reset", bus.in_ready_o, 0);

    run_pass(2, 1, 1, 2, 1, 0, 0, 0, 0);   // clean pass after reset

    check("wr_q_empty", wr_q.size(), 0);
    check("start_q_empty", start_q.size(), 0);
    check("out_q_empty", out_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
